// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF -> ID -> EXE handshake and ID/EX bundle for id_stage_pipe.
//   master : the decode stage (consumes instr/stall/flush, drives stall_out and
//            the ID/EX register outputs plus branch redirect).
//   slave  : the surrounding pipeline (IF/EXE side).
// Signals:
//   in_valid, instr        IF-presented instruction
//   stall_in, flush_in     EXE back-pressure / pipeline kill
//   stall_out              IF must hold instr
//   out_*                  ID/EX pipeline register contents
//   br_taken, br_off       registered branch redirect
interface id_stage_pipe_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned RA_W    = 4
);
    logic               in_valid;
    logic [INSTR_W-1:0] instr;
    logic               stall_in;
    logic               flush_in;
    logic               stall_out;
    logic               out_valid;
    logic [3:0]         out_cmd;
    logic [DATA_W-1:0]  out_val1;
    logic [DATA_W-1:0]  out_val2;
    logic [RA_W-1:0]    out_dest;
    logic               out_wb_en;
    logic               out_mem_r_en;
    logic               out_mem_w_en;
    logic [DATA_W-1:0]  out_st_data;
    logic               br_taken;
    logic [DATA_W-1:0]  br_off;

    modport master (
        input  in_valid, instr, stall_in, flush_in,
        output stall_out, out_valid, out_cmd, out_val1, out_val2, out_dest,
               out_wb_en, out_mem_r_en, out_mem_w_en, out_st_data,
               br_taken, br_off
    );

    modport slave (
        output in_valid, instr, stall_in, flush_in,
        input  stall_out, out_valid, out_cmd, out_val1, out_val2, out_dest,
               out_wb_en, out_mem_r_en, out_mem_w_en, out_st_data,
               br_taken, br_off
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered instruction decode stage with ID/EX register,
// load-use hazard bubble, Z-flag branch resolution and post-branch kill slot.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   bus (master)            IF/EXE handshake and ID/EX outputs (id_stage_pipe_if)
//   flag_z                  current Z flag
//   ex_dest, ex_mem_r_en    destination / load flag of the instruction in EXE
//   rf_raddr1/2             register-file read addresses (combinational)
//   rf_rdata1/2             register-file read data (same cycle)
// Optional build macro WB_BYPASS_EN adds wb_en/wb_dest/wb_data: a write-back
// whose destination matches a read address overrides that rf_rdata.
// Operand mapping not fixed by the ISA table:
//   MOVR: val2 = reg[7:4] via port 2
//   LDR : val1 = reg[7:4] (address), val2 = 0
//   STR : val1 = reg[7:4] (address), store data = reg[11:8] via port 2
//   Unused read ports idle on LINK_REG.
module id_stage_pipe #(
    parameter int unsigned     INSTR_W  = 16,
    parameter int unsigned     DATA_W   = 24,
    parameter int unsigned     RA_W     = 4,
    parameter int unsigned     IMM_W    = 8,
    parameter int unsigned     BR_W     = 12,
    parameter logic [RA_W-1:0] LINK_REG = RA_W'(4'hF)
) (
    input  logic              clk,
    input  logic              rst_n,
    id_stage_pipe_if.master   bus,
    input  logic              flag_z,
    input  logic [RA_W-1:0]   ex_dest,
    input  logic              ex_mem_r_en,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2
`ifdef WB_BYPASS_EN
    ,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0] wb_data
`endif
);

    if (DATA_W < IMM_W || DATA_W < BR_W || INSTR_W < 3 * RA_W + 4) begin : g_param_err
        $error("id_stage_pipe: DATA_W must cover IMM_W/BR_W and INSTR_W must hold opcode + 3 register fields");
    end

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_KILL   = 2'd2;

    localparam logic [1:0] V2_ZERO = 2'd0;
    localparam logic [1:0] V2_REG  = 2'd1;
    localparam logic [1:0] V2_IMM  = 2'd2;
    localparam logic [1:0] V2_BR   = 2'd3;

    // Decode
    logic [3:0]        op;
    logic [RA_W-1:0]   f_dst, f_s1, f_s2;
    logic [3:0]        dec_cmd;
    logic              use1, use2, v1_reg, st_sel;
    logic [1:0]        v2_sel;
    logic              dec_wb, dec_mr, dec_mw, is_br, br_cond;
    logic [DATA_W-1:0] sext_imm, sext_br, rdata1, rdata2;
    logic [DATA_W-1:0] dec_val1, dec_val2, dec_st;
    logic              hazard, taken;

    assign op       = bus.instr[INSTR_W-1 -: 4];
    assign f_dst    = bus.instr[3*RA_W-1 -: RA_W];
    assign f_s1     = bus.instr[2*RA_W-1 -: RA_W];
    assign f_s2     = bus.instr[RA_W-1:0];
    assign sext_imm = DATA_W'($signed(bus.instr[IMM_W-1:0]));
    assign sext_br  = DATA_W'($signed(bus.instr[BR_W-1:0]));

    always_comb begin
        dec_cmd   = op;
        rf_raddr1 = LINK_REG;
        rf_raddr2 = LINK_REG;
        use1      = 1'b0;
        use2      = 1'b0;
        v1_reg    = 1'b0;
        v2_sel    = V2_ZERO;
        st_sel    = 1'b0;
        dec_wb    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        is_br     = 1'b0;
        br_cond   = 1'b0;
        case (op)
            4'h0: dec_cmd = 4'h0;
            4'h1, 4'h2, 4'h3, 4'h4: begin
                rf_raddr1 = f_s1;  use1 = 1'b1; v1_reg = 1'b1;
                rf_raddr2 = f_s2;  use2 = 1'b1; v2_sel = V2_REG;
                dec_wb    = 1'b1;
            end
            4'h5: begin
                v2_sel = V2_IMM;
                dec_wb = 1'b1;
            end
            4'h6: begin
                rf_raddr2 = f_s1;  use2 = 1'b1; v2_sel = V2_REG;
                dec_wb    = 1'b1;
            end
            4'h7: begin
                rf_raddr1 = f_dst; use1 = 1'b1; v1_reg = 1'b1;
                rf_raddr2 = f_s1;  use2 = 1'b1; v2_sel = V2_REG;
            end
            4'h8: begin
                rf_raddr1 = f_s1;  use1 = 1'b1; v1_reg = 1'b1;
                dec_mr    = 1'b1;
                dec_wb    = 1'b1;
            end
            4'h9: begin
                rf_raddr1 = f_s1;  use1 = 1'b1; v1_reg = 1'b1;
                rf_raddr2 = f_dst; use2 = 1'b1; st_sel = 1'b1;
                dec_mw    = 1'b1;
            end
            4'hA: begin is_br = 1'b1; br_cond = 1'b1;    v2_sel = V2_BR; end
            4'hB: begin is_br = 1'b1; br_cond = flag_z;  v2_sel = V2_BR; end
            4'hC: begin is_br = 1'b1; br_cond = !flag_z; v2_sel = V2_BR; end
            default: dec_cmd = 4'h0;
        endcase
    end

    always_comb begin
        rdata1 = rf_rdata1;
        rdata2 = rf_rdata2;
`ifdef WB_BYPASS_EN
        if (wb_en && wb_dest == rf_raddr1) rdata1 = wb_data;
        if (wb_en && wb_dest == rf_raddr2) rdata2 = wb_data;
`endif
    end

    always_comb begin
        dec_val1 = v1_reg ? rdata1 : '0;
        dec_st   = st_sel ? rdata2 : '0;
        case (v2_sel)
            V2_REG:  dec_val2 = rdata2;
            V2_IMM:  dec_val2 = sext_imm;
            V2_BR:   dec_val2 = sext_br;
            default: dec_val2 = '0;
        endcase
    end

    // Only registers the opcode actually reads can create a load-use hazard.
    assign hazard = bus.in_valid && ex_mem_r_en &&
                    ((use1 && ex_dest == rf_raddr1) || (use2 && ex_dest == rf_raddr2));
    assign taken  = is_br && br_cond;

    // ID/EX register and FSM
    logic [1:0]        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_cmd_q, out_cmd_d;
    logic [DATA_W-1:0] out_val1_q, out_val1_d, out_val2_q, out_val2_d;
    logic [RA_W-1:0]   out_dest_q, out_dest_d;
    logic              out_wb_en_q, out_wb_en_d;
    logic              out_mem_r_en_q, out_mem_r_en_d;
    logic              out_mem_w_en_q, out_mem_w_en_d;
    logic [DATA_W-1:0] out_st_data_q, out_st_data_d;
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_off_q, br_off_d;
    logic              stall_out_c, load, clear;

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_cmd_d      = out_cmd_q;
        out_val1_d     = out_val1_q;
        out_val2_d     = out_val2_q;
        out_dest_d     = out_dest_q;
        out_wb_en_d    = out_wb_en_q;
        out_mem_r_en_d = out_mem_r_en_q;
        out_mem_w_en_d = out_mem_w_en_q;
        out_st_data_d  = out_st_data_q;
        // br_taken is a pulse: it drops on every edge it is not freshly set,
        // including held (stalled) cycles, so a stall never repeats it.
        br_taken_d     = 1'b0;
        br_off_d       = br_off_q;
        stall_out_c    = 1'b0;
        load           = 1'b0;
        clear          = 1'b0;

        if (bus.flush_in) begin
            clear   = 1'b1;
            state_d = ST_RUN;
        end else if (bus.stall_in) begin
            stall_out_c = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        stall_out_c = 1'b1;
                        clear       = 1'b1;
                        state_d     = ST_BUBBLE;
                    end else begin
                        load = 1'b1;
                    end
                end
                ST_BUBBLE: load = 1'b1;
                default: begin
                    // ST_KILL: wrong-path slot after a taken branch.
                    clear   = 1'b1;
                    state_d = ST_RUN;
                end
            endcase
        end

        if (load) begin
            state_d = ST_RUN;
            if (bus.in_valid) begin
                out_valid_d    = 1'b1;
                out_cmd_d      = dec_cmd;
                out_val1_d     = dec_val1;
                out_val2_d     = dec_val2;
                out_dest_d     = f_dst;
                out_wb_en_d    = dec_wb;
                out_mem_r_en_d = dec_mr;
                out_mem_w_en_d = dec_mw;
                out_st_data_d  = dec_st;
                if (taken) begin
                    br_taken_d = 1'b1;
                    br_off_d   = sext_br;
                    state_d    = ST_KILL;
                end
            end else begin
                clear = 1'b1;
            end
        end

        if (clear) begin
            out_valid_d    = 1'b0;
            out_cmd_d      = '0;
            out_val1_d     = '0;
            out_val2_d     = '0;
            out_dest_d     = '0;
            out_wb_en_d    = 1'b0;
            out_mem_r_en_d = 1'b0;
            out_mem_w_en_d = 1'b0;
            out_st_data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            out_valid_q    <= 1'b0;
            out_cmd_q      <= '0;
            out_val1_q     <= '0;
            out_val2_q     <= '0;
            out_dest_q     <= '0;
            out_wb_en_q    <= 1'b0;
            out_mem_r_en_q <= 1'b0;
            out_mem_w_en_q <= 1'b0;
            out_st_data_q  <= '0;
            br_taken_q     <= 1'b0;
            br_off_q       <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_cmd_q      <= out_cmd_d;
            out_val1_q     <= out_val1_d;
            out_val2_q     <= out_val2_d;
            out_dest_q     <= out_dest_d;
            out_wb_en_q    <= out_wb_en_d;
            out_mem_r_en_q <= out_mem_r_en_d;
            out_mem_w_en_q <= out_mem_w_en_d;
            out_st_data_q  <= out_st_data_d;
            br_taken_q     <= br_taken_d;
            br_off_q       <= br_off_d;
        end
    end

    assign bus.stall_out    = stall_out_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_cmd      = out_cmd_q;
    assign bus.out_val1     = out_val1_q;
    assign bus.out_val2     = out_val2_q;
    assign bus.out_dest     = out_dest_q;
    assign bus.out_wb_en    = out_wb_en_q;
    assign bus.out_mem_r_en = out_mem_r_en_q;
    assign bus.out_mem_w_en = out_mem_w_en_q;
    assign bus.out_st_data  = out_st_data_q;
    assign bus.br_taken     = br_taken_q;
    assign bus.br_off       = br_off_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe. Stimulus pushes the
// expected ID/EX contents for each driven cycle; a monitor pops and compares
// after every clock edge. The register file is modelled as reg[i] = {6{i}}.
module tb_id_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        flag_z;
    logic [3:0]  ex_dest;
    logic        ex_mem_r_en;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [23:0] rf_rdata1, rf_rdata2;
    logic        rf_zero;
`ifdef WB_BYPASS_EN
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [23:0] wb_data;
`endif

    id_stage_pipe_if #(.INSTR_W(16), .DATA_W(24), .RA_W(4)) bus ();

    id_stage_pipe #(
        .INSTR_W(16), .DATA_W(24), .RA_W(4), .IMM_W(8), .BR_W(12), .LINK_REG(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flag_z(flag_z),
        .ex_dest(ex_dest), .ex_mem_r_en(ex_mem_r_en),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
`ifdef WB_BYPASS_EN
        , .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rf_rdata1 = rf_zero ? 24'h0 : {6{rf_raddr1}};
        rf_rdata2 = rf_zero ? 24'h0 : {6{rf_raddr2}};
    end

    typedef struct {
        int          id;
        logic        valid;
        logic [3:0]  cmd;
        logic [23:0] v1;
        logic [23:0] v2;
        logic [3:0]  dest;
        logic        wb, mr, mw;
        logic [23:0] st;
        logic        bt;
        logic [23:0] bo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int id, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [3:0] c, input logic [23:0] a,
                                input logic [23:0] b, input logic [3:0] d, input logic wb,
                                input logic mr, input logic mw, input logic [23:0] st,
                                input logic bt, input logic [23:0] bo);
        exp_t e;
        e.id = 0; e.valid = v; e.cmd = c; e.v1 = a; e.v2 = b; e.dest = d;
        e.wb = wb; e.mr = mr; e.mw = mw; e.st = st; e.bt = bt; e.bo = bo;
        return e;
    endfunction

    function automatic exp_t zslot(input logic [23:0] bo);
        return mk(1'b0, 4'h0, 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, bo);
    endfunction

    // Plain register-result instruction (no memory, no branch).
    function automatic exp_t alu(input logic [3:0] c, input logic [23:0] a, input logic [23:0] b,
                                 input logic [3:0] d, input logic wb, input logic [23:0] bo);
        return mk(1'b1, c, a, b, d, wb, 1'b0, 1'b0, 24'h0, 1'b0, bo);
    endfunction

    task automatic step(input logic v, input logic [15:0] ins, input logic si, input logic fl,
                        input logic fz, input logic [3:0] ed, input logic em,
                        input logic exp_so, input exp_t e);
        exp_t x;
        @(negedge clk);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.stall_in = si;
        bus.flush_in = fl;
        flag_z       = fz;
        ex_dest      = ed;
        ex_mem_r_en  = em;
        #1;
        x    = e;
        x.id = step_no;
        chk("stall_out", step_no, 24'(bus.stall_out), 24'(exp_so));
        sb.push_back(x);
        step_no++;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("out_valid",    mon_e.id, 24'(bus.out_valid),    24'(mon_e.valid));
            chk("out_cmd",      mon_e.id, 24'(bus.out_cmd),      24'(mon_e.cmd));
            chk("out_val1",     mon_e.id, bus.out_val1,          mon_e.v1);
            chk("out_val2",     mon_e.id, bus.out_val2,          mon_e.v2);
            chk("out_dest",     mon_e.id, 24'(bus.out_dest),     24'(mon_e.dest));
            chk("out_wb_en",    mon_e.id, 24'(bus.out_wb_en),    24'(mon_e.wb));
            chk("out_mem_r_en", mon_e.id, 24'(bus.out_mem_r_en), 24'(mon_e.mr));
            chk("out_mem_w_en", mon_e.id, 24'(bus.out_mem_w_en), 24'(mon_e.mw));
            chk("out_st_data",  mon_e.id, bus.out_st_data,       mon_e.st);
            chk("br_taken",     mon_e.id, 24'(bus.br_taken),     24'(mon_e.bt));
            chk("br_off",       mon_e.id, bus.br_off,            mon_e.bo);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t addi_r1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = 16'h0;
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        flag_z       = 1'b0;
        ex_dest      = 4'h0;
        ex_mem_r_en  = 1'b0;
        rf_zero      = 1'b0;
`ifdef WB_BYPASS_EN
        wb_en   = 1'b0;
        wb_dest = 4'h0;
        wb_data = 24'h0;
`endif
        #12;
        chk("rst_out_valid", -1, 24'(bus.out_valid), 24'h0);
        chk("rst_out_cmd",   -1, 24'(bus.out_cmd),   24'h0);
        chk("rst_out_val2",  -1, bus.out_val2,       24'h0);
        chk("rst_br_taken",  -1, 24'(bus.br_taken),  24'h0);
        chk("rst_br_off",    -1, bus.br_off,         24'h0);
        @(negedge clk);
        rst_n = 1'b1;

        addi_r1 = alu(4'h5, 24'h0, 24'h000001, 4'h1, 1'b1, 24'hFFF800);

        // Basic decode, one per opcode class
        step(1, 16'h52FF, 0, 0, 0, 4'h0, 0, 0, alu(4'h5, 24'h0, 24'hFFFFFF, 4'h2, 1'b1, 24'h0));
        step(0, 16'h52FF, 0, 0, 0, 4'h0, 0, 0, zslot(24'h0));
        // Load-use on src1: one bubble, then the ADD with register data
        step(1, 16'h1134, 0, 0, 0, 4'h3, 1, 1, zslot(24'h0));
        step(1, 16'h1134, 0, 0, 0, 4'h0, 0, 0, alu(4'h1, 24'h333333, 24'h444444, 4'h1, 1'b1, 24'h0));
        // Load in EXE but no matching source: no stall
        step(1, 16'h1134, 0, 0, 0, 4'h5, 1, 0, alu(4'h1, 24'h333333, 24'h444444, 4'h1, 1'b1, 24'h0));
        step(1, 16'h5301, 0, 0, 0, 4'h3, 1, 0, alu(4'h5, 24'h0, 24'h000001, 4'h3, 1'b1, 24'h0));
        step(0, 16'h1134, 0, 0, 0, 4'h3, 1, 0, zslot(24'h0));
        step(1, 16'h9A30, 0, 0, 0, 4'h0, 0, 0,
             mk(1'b1, 4'h9, 24'h333333, 24'h0, 4'hA, 1'b0, 1'b0, 1'b1, 24'hAAAAAA, 1'b0, 24'h0));
        step(1, 16'h8250, 0, 0, 0, 4'h0, 0, 0,
             mk(1'b1, 4'h8, 24'h555555, 24'h0, 4'h2, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0));
        step(1, 16'h7C40, 0, 0, 0, 4'h0, 0, 0, alu(4'h7, 24'hCCCCCC, 24'h444444, 4'hC, 1'b0, 24'h0));
        step(1, 16'h6170, 0, 0, 0, 4'h0, 0, 0, alu(4'h6, 24'h0, 24'h777777, 4'h1, 1'b1, 24'h0));
        step(1, 16'hE123, 0, 0, 0, 4'h0, 0, 0, alu(4'h0, 24'h0, 24'h0, 4'h1, 1'b0, 24'h0));
        // Branches: BEQ not taken, BEQ taken, kill slot, recovery
        step(1, 16'hB010, 0, 0, 0, 4'h0, 0, 0, alu(4'hB, 24'h0, 24'h000010, 4'h0, 1'b0, 24'h0));
        step(1, 16'hB800, 0, 0, 1, 4'h0, 0, 0,
             mk(1'b1, 4'hB, 24'h0, 24'hFFF800, 4'h8, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'hFFF800));
        step(1, 16'h5101, 0, 0, 1, 4'h0, 0, 0, zslot(24'hFFF800));
        step(1, 16'h5101, 0, 0, 1, 4'h0, 0, 0, addi_r1);
        // Stall around a taken B: held outputs, single br_taken pulse
        for (int i = 0; i < 3; i++)
            step(1, 16'hA005, 1, 0, 0, 4'h0, 0, 1, addi_r1);
        step(1, 16'hA005, 0, 0, 0, 4'h0, 0, 0,
             mk(1'b1, 4'hA, 24'h0, 24'h000005, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h000005));
        for (int i = 0; i < 3; i++)
            step(1, 16'h5101, 1, 0, 0, 4'h0, 0, 1, alu(4'hA, 24'h0, 24'h000005, 4'h0, 1'b0, 24'h000005));
        step(1, 16'h5101, 0, 0, 0, 4'h0, 0, 0, zslot(24'h000005));
        // Flush overrides stall
        step(1, 16'h5101, 0, 0, 0, 4'h0, 0, 0, alu(4'h5, 24'h0, 24'h000001, 4'h1, 1'b1, 24'h000005));
        step(1, 16'h5101, 1, 1, 0, 4'h0, 0, 0, zslot(24'h000005));
        step(1, 16'h5101, 0, 0, 0, 4'h0, 0, 0, alu(4'h5, 24'h0, 24'h000001, 4'h1, 1'b1, 24'h000005));
        // Flush in the kill slot returns to RUN
        step(1, 16'hC003, 0, 0, 0, 4'h0, 0, 0,
             mk(1'b1, 4'hC, 24'h0, 24'h000003, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h000003));
        step(1, 16'h5101, 0, 1, 0, 4'h0, 0, 0, zslot(24'h000003));
        step(1, 16'h5101, 0, 0, 0, 4'h0, 0, 0, alu(4'h5, 24'h0, 24'h000001, 4'h1, 1'b1, 24'h000003));
        // Load-use on src2
        step(1, 16'h1134, 0, 0, 0, 4'h4, 1, 1, zslot(24'h000003));
        step(1, 16'h1134, 0, 0, 0, 4'h4, 0, 0, alu(4'h1, 24'h333333, 24'h444444, 4'h1, 1'b1, 24'h000003));
`ifdef WB_BYPASS_EN
        @(negedge clk);
        rf_zero = 1'b1;
        wb_en   = 1'b1;
        wb_dest = 4'h4;
        wb_data = 24'h123456;
        step(1, 16'h1134, 0, 0, 0, 4'h0, 0, 0, alu(4'h1, 24'h0, 24'h123456, 4'h1, 1'b1, 24'h000003));
        @(negedge clk);
        rf_zero = 1'b0;
        wb_en   = 1'b0;
`endif
        step(1, 16'h5101, 0, 0, 0, 4'h0, 0, 0, alu(4'h5, 24'h0, 24'h000001, 4'h1, 1'b1, 24'h000003));

        // Asynchronous reset in mid-cycle
        @(negedge clk);
        #2;
        chk("pre_rst_valid", -2, 24'(bus.out_valid), 24'h1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("arst_out_valid", -2, 24'(bus.out_valid), 24'h0);
        chk("arst_out_cmd",   -2, 24'(bus.out_cmd),   24'h0);
        chk("arst_out_val2",  -2, bus.out_val2,       24'h0);
        chk("arst_out_wb_en", -2, 24'(bus.out_wb_en), 24'h0);
        chk("arst_br_off",    -2, bus.br_off,         24'h0);
        #1;
        rst_n = 1'b1;
        step(1, 16'h52FF, 0, 0, 0, 4'h0, 0, 0, alu(4'h5, 24'h0, 24'hFFFFFF, 4'h2, 1'b1, 24'h0));

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
